// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: default widths,
// watchdog sizing and the 3-bit state encoding of the arbiter FSM.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;
    localparam int WAIT_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_D = 3'd1,
        BUSY_I = 3'd2,
        DONE_D = 3'd3,
        DONE_I = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == BUSY_D) || (s == BUSY_I);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Watchdog for one memory transaction: counts cycles spent waiting for
// mem_ack and flags expiry once the count reaches TIMEOUT-1.
module mem_wait_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [WAIT_CNT_W-1:0] count;

    // Count waiting cycles; restart from zero whenever the arbiter is not busy.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == WAIT_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch
// (read-only) and the MEM-stage data port. Data wins ties because it belongs
// to the older instruction. Each transaction is bounded by a watchdog whose
// expiry raises a sticky bus error.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    state_t state;
    logic   discard;
    logic   busy;
    logic   expired;
    logic   d_keep;
    logic   if_keep;

    assign busy = is_busy(state);

    mem_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (~busy),
        .run     (busy),
        .expired (expired)
    );

    // A requester that has let go at any point of its transaction, including
    // the completing cycle, must not see a done pulse or fresh read data.
    assign d_keep  = d_req  & ~discard;
    assign if_keep = if_req & ~discard;

    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req  & ~d_done;

    // Arbiter FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            bus_err   <= 1'b0;
            discard   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (d_req) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (if_req) begin
                        state    <= BUSY_I;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                BUSY_D: begin
                    if (!d_req) begin
                        discard <= 1'b1;
                    end
                    if (mem_ack || expired) begin
                        state   <= DONE_D;
                        mem_req <= 1'b0;
                        if (!mem_ack) begin
                            bus_err <= 1'b1;
                        end
                        if (d_keep) begin
                            d_done <= 1'b1;
                            if (!mem_ack) begin
                                d_rdata <= '0;
                            end else if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                BUSY_I: begin
                    if (!if_req) begin
                        discard <= 1'b1;
                    end
                    if (mem_ack || expired) begin
                        state   <= DONE_I;
                        mem_req <= 1'b0;
                        if (!mem_ack) begin
                            bus_err <= 1'b1;
                        end
                        if (if_keep) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end
                end
                DONE_D, DONE_I: begin
                    state   <= IDLE;
                    discard <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        bus_err;

    int vectors = 0;
    int miscompares = 0;
    bit model_on = 1'b0;

    // Memory behaviour controls.
    int          forced_latency = -1;
    bit          use_forced_rdata = 1'b0;
    logic [31:0] forced_rdata = '0;
    bit          inject_ack = 1'b0;
    bit          allow_spurious = 1'b0;
    int          countdown = -1;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: acks each request after a chosen number of waiting cycles.
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (countdown < 0) begin
                if (forced_latency >= 0) countdown = forced_latency;
                else if ($urandom_range(0, 19) == 0) countdown = 1000;
                else countdown = int'($urandom_range(0, 4));
            end else begin
                countdown--;
            end
            mem_ack = (countdown == 0);
        end else begin
            countdown = -1;
            mem_ack = inject_ack || (allow_spurious && ($urandom_range(0, 15) == 0));
        end
        mem_rdata = use_forced_rdata ? forced_rdata : $urandom();
    end

    // Transaction-level reference model.
    bit          m_active = 1'b0;
    bit          m_settle = 1'b0;
    bit          m_is_data = 1'b0;
    bit          m_withdrawn = 1'b0;
    int          m_busy = 0;
    logic        e_mem_req = 1'b0, e_mem_we = 1'b0, e_if_done = 1'b0, e_d_done = 1'b0, e_bus_err = 1'b0;
    logic [31:0] e_mem_addr = '0, e_mem_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_settle = 0; m_withdrawn = 0; m_busy = 0;
            e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
            e_if_rdata = '0; e_d_rdata = '0; e_if_done = 0; e_d_done = 0; e_bus_err = 0;
        end else begin
            e_if_done = 0;
            e_d_done = 0;
            if (m_settle) begin
                m_settle = 0;
            end else if (!m_active) begin
                if (d_req || if_req) begin
                    m_active = 1; m_is_data = d_req; m_busy = 0; m_withdrawn = 0;
                    e_mem_req = 1;
                    e_mem_addr = d_req ? d_addr : if_addr;
                    e_mem_we = d_req & d_we;
                    if (d_req) e_mem_wdata = d_wdata;
                end
            end else begin
                m_busy++;
                if (!(m_is_data ? d_req : if_req)) m_withdrawn = 1;
                if (mem_ack || m_busy == TIMEOUT) begin
                    m_active = 0; m_settle = 1; e_mem_req = 0;
                    if (!mem_ack) e_bus_err = 1;
                    if (!m_withdrawn) begin
                        if (m_is_data) begin
                            e_d_done = 1;
                            if (!mem_ack) e_d_rdata = '0;
                            else if (!e_mem_we) e_d_rdata = mem_rdata;
                        end else begin
                            e_if_done = 1;
                            e_if_rdata = mem_ack ? mem_rdata : '0;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (model_on) begin
            check_output("mem_req",   32'(mem_req),   32'(e_mem_req));
            check_output("mem_we",    32'(mem_we),    32'(e_mem_we));
            check_output("mem_addr",  mem_addr,       e_mem_addr);
            check_output("mem_wdata", mem_wdata,      e_mem_wdata);
            check_output("if_rdata",  if_rdata,       e_if_rdata);
            check_output("d_rdata",   d_rdata,        e_d_rdata);
            check_output("if_done",   32'(if_done),   32'(e_if_done));
            check_output("d_done",    32'(d_done),    32'(e_d_done));
            check_output("if_stall",  32'(if_stall),  32'(if_req & ~e_if_done));
            check_output("d_stall",   32'(d_stall),   32'(d_req & ~e_d_done));
            check_output("bus_err",   32'(bus_err),   32'(e_bus_err));
        end
    end

    // Observe one transaction whose request was raised in the current cycle.
    task automatic run_txn(input bit is_data, input int drop_at, input logic [31:0] exp_addr,
                           input logic exp_we, input logic [31:0] exp_wdata,
                           output int done_at, output int req_cycles, output int field_errs,
                           output int stall_at_done);
        done_at = -1; req_cycles = 0; field_errs = 0; stall_at_done = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                if (mem_addr !== exp_addr || mem_we !== exp_we || (exp_we && mem_wdata !== exp_wdata))
                    field_errs++;
            end
            if ((is_data ? d_done : if_done) && done_at < 0) begin
                done_at = i;
                stall_at_done = int'(is_data ? d_stall : if_stall);
            end
            @(posedge clk); #1;
            if (i + 1 == drop_at || done_at >= 0) begin
                if (is_data) d_req = 0; else if_req = 0;
                d_we = 0;
            end
            if (done_at >= 0 && i >= done_at + 1) break;
        end
    endtask

    task automatic apply_stimulus();
        if (rst) rst = 0;
        else if ($urandom_range(0, 299) == 0) rst = 1;
        if (if_req) begin
            if (if_done) begin
                if ($urandom_range(0, 1) == 1) if_addr = $urandom() & 32'hFFFF_FFFC;
                else if_req = 0;
            end else if ($urandom_range(0, 39) == 0) if_req = 0;
        end else if ($urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (d_req) begin
            if (d_done) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_addr = $urandom(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
                end else d_req = 0;
            end else if ($urandom_range(0, 39) == 0) d_req = 0;
        end else if ($urandom_range(0, 3) == 0) begin
            d_req = 1; d_addr = $urandom(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
        end
    endtask

    int done_at, req_cycles, field_errs, stall_at_done, anomalies;
    int d_done_at, i_done_at, stall_low;

    initial begin
        // Reset state.
        @(posedge clk); #1;
        @(negedge clk);
        check_output("reset mem_req", 32'(mem_req), 32'd0);
        check_output("reset bus_err", 32'(bus_err), 32'd0);
        check_output("reset mem_addr", mem_addr, 32'd0);
        check_output("reset if_done", 32'(if_done), 32'd0);
        @(posedge clk); #1;
        rst = 0; model_on = 1;
        use_forced_rdata = 1;

        // Fetch from 0x40, memory acks two cycles after mem_req.
        forced_latency = 2; forced_rdata = 32'hE3A0_1005;
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h40;
        run_txn(0, -1, 32'h40, 0, 32'h0, done_at, req_cycles, field_errs, stall_at_done);
        check_output("fetch done cycle", 32'(done_at), 32'd4);
        check_output("fetch mem_req cycles", 32'(req_cycles), 32'd3);
        check_output("fetch mem fields", 32'(field_errs), 32'd0);
        check_output("fetch stall at done", 32'(stall_at_done), 32'd0);
        check_output("fetch if_rdata", if_rdata, 32'hE3A0_1005);

        // Simultaneous requests: data first, one IDLE cycle, then fetch.
        forced_latency = 1; forced_rdata = 32'h1234_5678;
        d_done_at = -1; i_done_at = -1; stall_low = 0;
        if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h100;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 1) check_output("both first addr", mem_addr, 32'h100);
            if (i == 5) check_output("both second addr", mem_addr, 32'h44);
            if (d_done && d_done_at < 0) d_done_at = i;
            if (if_done && i_done_at < 0) i_done_at = i;
            if (i_done_at < 0 && !if_stall) stall_low++;
            @(posedge clk); #1;
            if (d_done_at >= 0) d_req = 0;
            if (i_done_at >= 0) if_req = 0;
            if (i_done_at >= 0 && i >= i_done_at + 1) break;
        end
        check_output("both d_done cycle", 32'(d_done_at), 32'd3);
        check_output("both if_done cycle", 32'(i_done_at), 32'd7);
        check_output("both if_stall gaps", 32'(stall_low), 32'd0);
        check_output("both d_rdata", d_rdata, 32'h1234_5678);

        // Data write: fields stable until ack, d_rdata untouched.
        forced_latency = 3; forced_rdata = 32'h0BAD_F00D;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        run_txn(1, -1, 32'h200, 1, 32'hDEAD_BEEF, done_at, req_cycles, field_errs, stall_at_done);
        check_output("write done cycle", 32'(done_at), 32'd5);
        check_output("write mem_req cycles", 32'(req_cycles), 32'd4);
        check_output("write mem fields", 32'(field_errs), 32'd0);
        check_output("write d_rdata kept", d_rdata, 32'h1234_5678);

        // Fetch withdrawn in its second BUSY cycle, then a normal fetch.
        forced_latency = 3; forced_rdata = 32'h55AA_55AA;
        if_req = 1; if_addr = 32'h60;
        run_txn(0, 2, 32'h60, 0, 32'h0, done_at, req_cycles, field_errs, stall_at_done);
        check_output("flush no done", 32'(done_at), 32'hFFFF_FFFF);
        check_output("flush mem_req cycles", 32'(req_cycles), 32'd4);
        check_output("flush if_rdata kept", if_rdata, 32'h1234_5678);
        forced_latency = 0; forced_rdata = 32'hCAFE_F00D;
        if_req = 1; if_addr = 32'h80;
        run_txn(0, -1, 32'h80, 0, 32'h0, done_at, req_cycles, field_errs, stall_at_done);
        check_output("refetch done cycle", 32'(done_at), 32'd2);
        check_output("refetch if_rdata", if_rdata, 32'hCAFE_F00D);

        // Memory never acks: timeout after TIMEOUT busy cycles.
        forced_latency = 1000; forced_rdata = 32'h7777_7777;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        run_txn(1, -1, 32'h300, 0, 32'h0, done_at, req_cycles, field_errs, stall_at_done);
        check_output("timeout done cycle", 32'(done_at), 32'd17);
        check_output("timeout mem_req cycles", 32'(req_cycles), 32'd16);
        check_output("timeout d_rdata", d_rdata, 32'h0);
        check_output("timeout bus_err", 32'(bus_err), 32'd1);
        inject_ack = 1; anomalies = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (d_done || if_done || mem_req || !bus_err) anomalies++;
            @(posedge clk); #1;
            inject_ack = 0;
        end
        check_output("late ack ignored", 32'(anomalies), 32'd0);
        forced_latency = 0; forced_rdata = 32'h1111_2222;
        if_req = 1; if_addr = 32'h84;
        run_txn(0, -1, 32'h84, 0, 32'h0, done_at, req_cycles, field_errs, stall_at_done);
        check_output("post-timeout done", 32'(done_at), 32'd2);
        check_output("bus_err sticky", 32'(bus_err), 32'd1);

        // Reset in BUSY_D abandons the transaction.
        forced_latency = 1000;
        d_req = 1; d_we = 0; d_addr = 32'h400;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        rst = 1; d_req = 0;
        @(negedge clk); @(posedge clk); #1;
        rst = 0; inject_ack = 1;
        @(negedge clk);
        check_output("rst mem_req", 32'(mem_req), 32'd0);
        check_output("rst mem_addr", mem_addr, 32'h0);
        check_output("rst bus_err", 32'(bus_err), 32'd0);
        check_output("rst d_rdata", d_rdata, 32'h0);
        check_output("rst if_rdata", if_rdata, 32'h0);
        anomalies = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            inject_ack = 0;
            @(negedge clk);
            if (d_done || if_done || mem_req) anomalies++;
        end
        check_output("ack after rst ignored", 32'(anomalies), 32'd0);

        // Randomized traffic.
        forced_latency = -1; use_forced_rdata = 0; allow_spurious = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            apply_stimulus();
        end
        if_req = 0; d_req = 0; rst = 0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
